// File: rtl/axi4_lite_master.sv
// axi4_lite_master: single-outstanding AXI4-Lite initiator driven by a local command port.
// Optional transaction timeout is compiled in with `define AXI_TIMEOUT_EN.
module axi4_lite_master #(
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDR_BITS-1:0] cmd_addr,
  input  logic [31:0]          cmd_wdata,
  input  logic [3:0]           cmd_wstrb,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic [1:0]           rsp_resp,
  output logic                 rsp_timeout,
  output logic [ADDR_BITS-1:0] m_axi_awaddr,
  output logic                 m_axi_awvalid,
  input  logic                 m_axi_awready,
  output logic [31:0]          m_axi_wdata,
  output logic [3:0]           m_axi_wstrb,
  output logic                 m_axi_wvalid,
  input  logic                 m_axi_wready,
  input  logic [1:0]           m_axi_bresp,
  input  logic                 m_axi_bvalid,
  output logic                 m_axi_bready,
  output logic [ADDR_BITS-1:0] m_axi_araddr,
  output logic                 m_axi_arvalid,
  input  logic                 m_axi_arready,
  input  logic [31:0]          m_axi_rdata,
  input  logic [1:0]           m_axi_rresp,
  input  logic                 m_axi_rvalid,
  output logic                 m_axi_rready
);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR_DATA,
    WR_RESP,
    RD_ADDR,
    RD_DATA
  } state_t;

  state_t               state;
  logic                 rsp_pend;
  logic [ADDR_BITS-1:0] addr_q;
  logic                 aw_fin;
  logic                 w_fin;

  assign m_axi_awaddr = addr_q;
  assign m_axi_araddr = addr_q;

  // Idle is the only state that takes commands; held low while in reset.
  assign cmd_ready = (state == IDLE) && !rst;

  // A write channel is finished once its valid is gone or handshakes now.
  assign aw_fin = !m_axi_awvalid || m_axi_awready;
  assign w_fin  = !m_axi_wvalid || m_axi_wready;

`ifdef AXI_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] to_cnt;
  logic          hs;
  logic          expire;

  // Any handshake this cycle counts as progress and beats the timeout.
  always_comb begin
    hs = 1'b0;
    if (state == WR_ADDR_DATA)
      hs = (m_axi_awvalid && m_axi_awready) ||
           (m_axi_wvalid && m_axi_wready);
    if (state == WR_RESP)
      hs = m_axi_bready && m_axi_bvalid;
    if (state == RD_ADDR)
      hs = m_axi_arvalid && m_axi_arready;
    if (state == RD_DATA)
      hs = m_axi_rready && m_axi_rvalid;
    expire = (state != IDLE) && !rsp_pend && !hs &&
             (to_cnt == CW'(TIMEOUT_CYCLES - 2));
  end

  // Cycle counter: cleared on accept, counts every busy cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      to_cnt <= '0;
    else if (cmd_valid && cmd_ready)
      to_cnt <= '0;
    else if (state != IDLE)
      to_cnt <= to_cnt + 1'b1;
  end
`else
  // TIMEOUT_CYCLES only matters when the timeout build is selected.
  assign rsp_timeout = 1'b0 & (TIMEOUT_CYCLES == 0);
`endif

  // Transaction FSM with registered AXI and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      rsp_pend      <= 1'b0;
      addr_q        <= '0;
      m_axi_wdata   <= '0;
      m_axi_wstrb   <= '0;
      m_axi_awvalid <= 1'b0;
      m_axi_wvalid  <= 1'b0;
      m_axi_bready  <= 1'b0;
      m_axi_arvalid <= 1'b0;
      m_axi_rready  <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_resp      <= '0;
`ifdef AXI_TIMEOUT_EN
      rsp_timeout   <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q      <= cmd_addr;
            m_axi_wdata <= cmd_wdata;
            m_axi_wstrb <= cmd_wstrb;
            if (cmd_write) begin
              m_axi_awvalid <= 1'b1;
              m_axi_wvalid  <= 1'b1;
              state         <= WR_ADDR_DATA;
            end else begin
              m_axi_arvalid <= 1'b1;
              state         <= RD_ADDR;
            end
          end
        end
        WR_ADDR_DATA: begin
          if (m_axi_awvalid && m_axi_awready)
            m_axi_awvalid <= 1'b0;
          if (m_axi_wvalid && m_axi_wready)
            m_axi_wvalid <= 1'b0;
          if (aw_fin && w_fin) begin
            m_axi_bready <= 1'b1;
            state        <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (rsp_pend) begin
            rsp_pend  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end else if (m_axi_bvalid) begin
            m_axi_bready <= 1'b0;
            rsp_resp     <= m_axi_bresp;
            rsp_rdata    <= '0;
            rsp_pend     <= 1'b1;
`ifdef AXI_TIMEOUT_EN
            rsp_timeout  <= 1'b0;
`endif
          end
        end
        RD_ADDR: begin
          if (m_axi_arready) begin
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b1;
            state         <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (rsp_pend) begin
            rsp_pend  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= IDLE;
          end else if (m_axi_rvalid) begin
            m_axi_rready <= 1'b0;
            rsp_rdata    <= m_axi_rdata;
            rsp_resp     <= m_axi_rresp;
            rsp_pend     <= 1'b1;
`ifdef AXI_TIMEOUT_EN
            rsp_timeout  <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
`ifdef AXI_TIMEOUT_EN
      if (expire) begin
        m_axi_awvalid <= 1'b0;
        m_axi_wvalid  <= 1'b0;
        m_axi_bready  <= 1'b0;
        m_axi_arvalid <= 1'b0;
        m_axi_rready  <= 1'b0;
        rsp_pend      <= 1'b0;
        rsp_valid     <= 1'b1;
        rsp_timeout   <= 1'b1;
        rsp_resp      <= 2'b10;
        rsp_rdata     <= '0;
        state         <= IDLE;
      end
`endif
    end
  end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb_axi4_lite_master: directed bench with a configurable AXI4-Lite slave
// and a response scoreboard.
module tb_axi4_lite_master;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic [3:0]    cmd_wstrb;
  logic          rsp_valid, rsp_timeout;
  logic [31:0]   rsp_rdata;
  logic [1:0]    rsp_resp;
  logic [AW-1:0] awaddr, araddr;
  logic          awvalid, awready, wvalid, wready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          bvalid, bready, arvalid, arready, rvalid, rready;

  always #5 clk = ~clk;

  axi4_lite_master #(.ADDR_BITS(AW), .TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
    .m_axi_awaddr(awaddr), .m_axi_awvalid(awvalid),
    .m_axi_awready(awready),
    .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
    .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid),
    .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arvalid(arvalid),
    .m_axi_arready(arready),
    .m_axi_rdata(rdata), .m_axi_rresp(rresp),
    .m_axi_rvalid(rvalid), .m_axi_rready(rready)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // slave model
  int          aw_wait = 0, w_wait = 0, ar_wait = 0, r_wait = 0;
  logic        ar_never = 1'b0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [31:0] rdata_cfg = '0;
  int          aw_cnt, w_cnt, ar_cnt, r_cnt;
  logic        got_aw, got_w, r_active, bvalid_q;
  logic        aw_now, w_now;

  assign awready = awvalid && (aw_cnt == aw_wait);
  assign wready  = wvalid && (w_cnt == w_wait);
  assign arready = arvalid && !ar_never && (ar_cnt == ar_wait);
  assign rvalid  = r_active && (r_cnt == r_wait);
  assign rdata   = rvalid ? rdata_cfg : 32'h0;
  assign rresp   = rresp_cfg;
  assign bresp   = bresp_cfg;
  assign bvalid  = bvalid_q;
  assign aw_now  = got_aw | (awvalid & awready);
  assign w_now   = got_w | (wvalid & wready);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_cnt <= 0; w_cnt <= 0; ar_cnt <= 0; r_cnt <= 0;
      got_aw <= 1'b0; got_w <= 1'b0;
      r_active <= 1'b0; bvalid_q <= 1'b0;
    end else begin
      aw_cnt <= (awvalid && !awready) ? aw_cnt + 1 : 0;
      w_cnt  <= (wvalid && !wready) ? w_cnt + 1 : 0;
      ar_cnt <= (arvalid && !arready) ? ar_cnt + 1 : 0;
      if (r_active) begin
        if (rvalid && rready) begin
          r_active <= 1'b0;
          r_cnt    <= 0;
        end else if (!rvalid) begin
          r_cnt <= r_cnt + 1;
        end
      end else if (arvalid && arready) begin
        r_active <= 1'b1;
        r_cnt    <= 0;
      end
      if (bvalid_q && bready) bvalid_q <= 1'b0;
      if (aw_now && w_now) begin
        bvalid_q <= 1'b1;
        got_aw   <= 1'b0;
        got_w    <= 1'b0;
      end else begin
        got_aw <= aw_now;
        got_w  <= w_now;
      end
    end
  end

  // scoreboard and channel monitor
  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        tmo;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          aw_beats = 0, w_beats = 0, b_beats = 0, ar_beats = 0;
  int          rsp_cnt = 0;
  int          aw_cyc, w_cyc;
  logic        wv_at_aw, rsp_prev = 1'b0;
  logic [AW-1:0] aw_seen, ar_seen;
  logic [31:0] w_seen;
  logic [3:0]  s_seen;

  always @(negedge clk) begin
    if (!rst) begin
      if (awvalid && awready) begin
        aw_beats++; aw_seen = awaddr; aw_cyc = cyc; wv_at_aw = wvalid;
      end
      if (wvalid && wready) begin
        w_beats++; w_seen = wdata; s_seen = wstrb; w_cyc = cyc;
      end
      if (bvalid && bready) b_beats++;
      if (arvalid && arready) begin
        ar_beats++; ar_seen = araddr;
      end
      if (rsp_valid) begin
        exp_t e;
        rsp_cnt++;
        chk("rsp_single_pulse", {31'b0, rsp_prev}, 0);
        chk("rsp_expected", {31'b0, sb.size() > 0}, 1);
        if (sb.size() > 0) begin
          e = sb.pop_front();
          chk("rsp_rdata", rsp_rdata, e.rdata);
          chk("rsp_resp", {30'b0, rsp_resp}, {30'b0, e.resp});
          chk("rsp_timeout", {31'b0, rsp_timeout}, {31'b0, e.tmo});
          chk("rsp_latency", cyc - e.acc + 1, e.lat);
        end
      end
      rsp_prev = rsp_valid;
    end else begin
      rsp_prev = 1'b0;
    end
  end

  task automatic issue(input logic wr, input logic [AW-1:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] er, input logic [1:0] ers,
                       input logic et, input int lat, output int acc);
    exp_t e;
    int n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("cmd_ready_wait", {31'b0, cmd_ready}, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a;
    cmd_wdata = d; cmd_wstrb = s;
    @(posedge clk);
    #1;
    acc = cyc;
    e.rdata = er; e.resp = ers; e.tmo = et; e.acc = acc; e.lat = lat;
    sb.push_back(e);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((!cmd_ready || sb.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'b0, n < 500}, 1);
    @(negedge clk);
  endtask

  int acc, acc2, n0, rc;

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0;
    cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(negedge clk);
    chk("rst_awvalid", {31'b0, awvalid}, 0);
    chk("rst_wvalid", {31'b0, wvalid}, 0);
    chk("rst_arvalid", {31'b0, arvalid}, 0);
    chk("rst_bready", {31'b0, bready}, 0);
    chk("rst_rready", {31'b0, rready}, 0);
    chk("rst_rsp_valid", {31'b0, rsp_valid}, 0);
    chk("rst_awaddr", {24'b0, awaddr}, 0);
    chk("rst_wdata", wdata, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_cmd_ready", {31'b0, cmd_ready}, 1);

    // zero-wait write
    issue(1'b1, 8'h04, 32'hDEADBEEF, 4'hF, 32'h0, 2'b00, 1'b0, 4, acc);
    wait_idle();
    chk("t1_aw_beats", aw_beats, 1);
    chk("t1_w_beats", w_beats, 1);
    chk("t1_b_beats", b_beats, 1);
    chk("t1_awaddr", {24'b0, aw_seen}, 32'h04);
    chk("t1_wdata", w_seen, 32'hDEADBEEF);
    chk("t1_wstrb", {28'b0, s_seen}, 32'hF);

    // read with three wait cycles on R
    r_wait = 3; rdata_cfg = 32'h12345678; rc = rsp_cnt;
    issue(1'b0, 8'h08, 32'h0, 4'h0, 32'h12345678, 2'b00, 1'b0, 7, acc);
    wait_idle();
    chk("t2_ar_beats", ar_beats, 1);
    chk("t2_araddr", {24'b0, ar_seen}, 32'h08);
    chk("t2_rsp_count", rsp_cnt - rc, 1);
    r_wait = 0;

    // slow AW, fast W
    aw_wait = 5; w_wait = 1; n0 = b_beats;
    issue(1'b1, 8'h0C, 32'hCAFEF00D, 4'h3, 32'h0, 2'b00, 1'b0, 9, acc);
    wait_idle();
    chk("t3_aw_cycle", aw_cyc - acc, 5);
    chk("t3_w_cycle", w_cyc - acc, 1);
    chk("t3_wvalid_at_aw", {31'b0, wv_at_aw}, 0);
    chk("t3_b_beats", b_beats - n0, 1);
    chk("t3_wdata", w_seen, 32'hCAFEF00D);
    chk("t3_wstrb", {28'b0, s_seen}, 32'h3);
    aw_wait = 0; w_wait = 0;

    // SLVERR write followed by a back-to-back read
    bresp_cfg = 2'b10; rdata_cfg = 32'hAABBCCDD;
    issue(1'b1, 8'h10, 32'h1, 4'h1, 32'h0, 2'b10, 1'b0, 4, acc);
    n0 = 0;
    while (!cmd_ready && n0 < 50) begin
      @(negedge clk);
      n0++;
    end
    chk("t4_b2b_rsp_valid", {31'b0, rsp_valid}, 1);
    issue(1'b0, 8'h14, 32'h0, 4'h0, 32'hAABBCCDD, 2'b00, 1'b0, 4, acc2);
    chk("t4_b2b_accept", acc2 - acc, 4);
    wait_idle();
    bresp_cfg = 2'b00;

    // reset during a write address phase
    aw_wait = 20; w_wait = 20;
    issue(1'b1, 8'h18, 32'h55, 4'hF, 32'h0, 2'b00, 1'b0, 0, acc);
    repeat (2) @(negedge clk);
    chk("t5_awvalid_before", {31'b0, awvalid}, 1);
    rc = rsp_cnt;
    rst = 1'b1;
    #1;
    chk("t5_awvalid_rst", {31'b0, awvalid}, 0);
    chk("t5_wvalid_rst", {31'b0, wvalid}, 0);
    chk("t5_rsp_valid_rst", {31'b0, rsp_valid}, 0);
    sb.delete();
    aw_wait = 0; w_wait = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t5_no_rsp", rsp_cnt - rc, 0);
    chk("t5_cmd_ready", {31'b0, cmd_ready}, 1);
    rdata_cfg = 32'h0BADF00D;
    issue(1'b0, 8'h1C, 32'h0, 4'h0, 32'h0BADF00D, 2'b00, 1'b0, 4, acc);
    wait_idle();

`ifdef AXI_TIMEOUT_EN
    // slave never accepts the read address
    ar_never = 1'b1;
    issue(1'b0, 8'h20, 32'h0, 4'h0, 32'h0, 2'b10, 1'b1, 16, acc);
    wait_idle();
    chk("t6_arvalid_dropped", {31'b0, arvalid}, 0);
    ar_never = 1'b0;
`endif

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
